// File: rtl/switch_pkg.sv
// Shared switch definitions: completion status codes,
// FSM state constants and the broadcast address helper.
package switch_pkg;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NOROUTE = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // All-ones address of width w (w < 64); callers truncate.
  function automatic logic [63:0] bcast_addr(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/switch_fifo.sv
// Synchronous FIFO for queued {addr,data} packets.
// Ports: push/wdata in, pop/rdata out, level/full/empty status.
module switch_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/switch_buffered.sv
// Buffered packet switch: input FIFO, learnable address table,
// per-port req/received delivery with timeout and done status.
// Ports: cfg_* table writes, in_* packet input, port_* delivery,
// done_* per-packet completion.
module switch_buffered
  import switch_pkg::*;
#(
  parameter int NUM_OF_PORTS     = 10,
  parameter int PORT_ADDR_LENGTH = 8,
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES   = 16,
  parameter int BCAST_EN         = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cfg_wr,
  input  logic                               cfg_clr,
  input  logic [$clog2(NUM_OF_PORTS)-1:0]    cfg_index,
  input  logic [PORT_ADDR_LENGTH-1:0]        cfg_addr,
  output logic                               cfg_err,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [PORT_ADDR_LENGTH-1:0]        in_addr,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic [NUM_OF_PORTS-1:0]            port_req,
  output logic [NUM_OF_PORTS*DATA_WIDTH-1:0] port_data,
  input  logic [NUM_OF_PORTS-1:0]            port_received,
  output logic                               done_valid,
  output logic [1:0]                         done_status
);

  localparam int IW = $clog2(NUM_OF_PORTS);
  localparam int AL = PORT_ADDR_LENGTH;
  localparam int FW = AL + DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [AL-1:0] BCAST = AL'(bcast_addr(AL));

  logic [NUM_OF_PORTS-1:0] tbl_v;
  logic [AL-1:0]           tbl_a [NUM_OF_PORTS];

  logic [1:0]              state;
  logic [AL-1:0]           pkt_addr;
  logic [DATA_WIDTH-1:0]   pkt_data;
  logic [NUM_OF_PORTS-1:0] mask;
  logic [NUM_OF_PORTS-1:0] acked;
  logic [NUM_OF_PORTS-1:0] acked_nx;
  logic [NUM_OF_PORTS-1:0] route;
  logic [TW-1:0]           timer;
  logic [1:0]              status;

  logic          f_full;
  logic          f_empty;
  logic          f_pop;
  logic [FW-1:0] f_rdata;

  logic idx_ok;
  logic dup;
  logic cfg_ok;
  logic is_bcast;
  logic tmo;

  assign in_ready = reset_n && !f_full;
  assign f_pop    = (state == S_IDLE) && !f_empty;

  switch_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_valid && in_ready),
    .pop     (f_pop),
    .wdata   ({in_addr, in_data}),
    .rdata   (f_rdata),
    .level   (fifo_level),
    .full    (f_full),
    .empty   (f_empty)
  );

  // An address may be bound to only one port; rebinding the
  // same address at its own index is harmless.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      if (tbl_v[i] && tbl_a[i] == cfg_addr && IW'(i) != cfg_index)
        dup = 1'b1;
    end
  end

  assign idx_ok = 32'(cfg_index) < 32'(NUM_OF_PORTS);
  assign cfg_ok = idx_ok && (cfg_clr ||
                  (cfg_addr != '0 && !dup &&
                   !(BCAST_EN != 0 && cfg_addr == BCAST)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tbl_v   <= '0;
      cfg_err <= 1'b0;
      for (int i = 0; i < NUM_OF_PORTS; i++)
        tbl_a[i] <= '0;
    end else begin
      cfg_err <= cfg_wr && !cfg_ok;
      if (cfg_wr && cfg_ok) begin
        tbl_v[cfg_index] <= !cfg_clr;
        if (!cfg_clr) tbl_a[cfg_index] <= cfg_addr;
      end
    end
  end

  assign is_bcast = BCAST_EN != 0 && pkt_addr == BCAST;

  always_comb begin
    route = '0;
    for (int i = 0; i < NUM_OF_PORTS; i++)
      route[i] = tbl_v[i] && pkt_addr != '0 &&
                 (is_bcast || tbl_a[i] == pkt_addr);
  end

  assign acked_nx = acked | (port_received & mask);
  assign tmo = TIMEOUT_CYCLES != 0 &&
               timer == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      pkt_addr <= '0;
      pkt_data <= '0;
      mask     <= '0;
      acked    <= '0;
      timer    <= '0;
      status   <= ST_OK;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!f_empty) begin
            pkt_addr <= f_rdata[FW-1:DATA_WIDTH];
            pkt_data <= f_rdata[DATA_WIDTH-1:0];
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          mask  <= route;
          acked <= '0;
          timer <= '0;
          if (route == '0) begin
            status <= ST_NOROUTE;
            state  <= S_DONE;
          end else begin
            state <= S_SEND;
          end
        end
        S_SEND: begin
          acked <= acked_nx;
          // Completion is checked first so it beats a same-cycle timeout.
          if (acked_nx == mask) begin
            status <= ST_OK;
            state  <= S_DONE;
          end else if (tmo) begin
            status <= ST_TIMEOUT;
            state  <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign port_req    = (state == S_SEND) ? (mask & ~acked) : '0;
  assign done_valid  = state == S_DONE;
  assign done_status = (state == S_DONE) ? status : 2'b00;

  for (genvar g = 0; g < NUM_OF_PORTS; g++) begin : g_pd
    assign port_data[g*DATA_WIDTH +: DATA_WIDTH] =
      port_req[g] ? pkt_data : '0;
  end

endmodule

// File: tb/tb_switch_buffered.sv
// Self-checking bench for switch_buffered: table vectors,
// routed/broadcast/timeout/fill/reset sequences, scoreboard.
module tb_switch_buffered;

  localparam int NP = 10;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            cfg_wr = 1'b0;
  logic            cfg_clr = 1'b0;
  logic [3:0]      cfg_index = '0;
  logic [7:0]      cfg_addr = '0;
  logic            cfg_err;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      in_addr = '0;
  logic [7:0]      in_data = '0;
  logic [2:0]      fifo_level;
  logic [NP-1:0]   port_req;
  logic [NP*DW-1:0] port_data;
  logic [NP-1:0]   port_received = '0;
  logic            done_valid;
  logic [1:0]      done_status;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NP-1:0] mask;
    logic [DW-1:0] data;
    logic [1:0]    st;
  } exp_t;

  typedef struct {
    logic       clr;
    logic [3:0] idx;
    logic [7:0] addr;
    logic       err;
  } cfg_vec_t;

  exp_t sb[$];

  switch_buffered dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_wr        (cfg_wr),
    .cfg_clr       (cfg_clr),
    .cfg_index     (cfg_index),
    .cfg_addr      (cfg_addr),
    .cfg_err       (cfg_err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .fifo_level    (fifo_level),
    .port_req      (port_req),
    .port_data     (port_data),
    .port_received (port_received),
    .done_valid    (done_valid),
    .done_status   (done_status)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic clr, input logic [3:0] idx,
                     input logic [7:0] a, input logic err,
                     input string nm);
    cfg_wr    = 1'b1;
    cfg_clr   = clr;
    cfg_index = idx;
    cfg_addr  = a;
    tick();
    cfg_wr  = 1'b0;
    cfg_clr = 1'b0;
    chk(nm, cfg_err, err);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d,
                      input logic [NP-1:0] m, input logic [1:0] st,
                      input bit track);
    int n = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready", in_ready, 1'b1);
    if (in_ready && track) sb.push_back('{m, d, st});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input int lim);
    int n = 0;
    while (port_req == '0 && n < lim) begin
      tick();
      n++;
    end
    chk("req_seen", port_req != '0, 1'b1);
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done_valid && n < lim) begin
      tick();
      n++;
    end
    chk("done_seen", done_valid, 1'b1);
    tick();
  endtask

  // Monitor: slice/req checks while sending, scoreboard on done.
  bit             seen = 0;
  logic [NP-1:0]  seen_mask;
  logic [NP*DW-1:0] epd;
  exp_t           me;

  always @(negedge clk) begin
    if (!reset_n) begin
      seen = 0;
    end else begin
      if (port_req != '0 && sb.size() != 0) begin
        epd = '0;
        for (int j = 0; j < NP; j++)
          if (port_req[j]) epd[j*DW +: DW] = sb[0].data;
        chk("mon_pdata", port_data, epd);
        chk("mon_req_in_mask", port_req & ~sb[0].mask, '0);
        if (!seen) begin
          seen = 1;
          seen_mask = port_req;
        end
      end
      if (done_valid) begin
        if (sb.size() == 0) begin
          chk("mon_done_extra", done_valid, 1'b0);
        end else begin
          me = sb.pop_front();
          chk("mon_mask", seen ? seen_mask : '0, me.mask);
          chk("mon_status", done_status, me.st);
        end
        seen = 0;
      end
    end
  end

  cfg_vec_t vt[10];
  int cnt;
  int acc;

  initial begin
    vt[0] = '{1'b0, 4'd3,  8'h21, 1'b0};
    vt[1] = '{1'b0, 4'd5,  8'h21, 1'b1};
    vt[2] = '{1'b0, 4'd3,  8'h21, 1'b0};
    vt[3] = '{1'b0, 4'd4,  8'h00, 1'b1};
    vt[4] = '{1'b0, 4'd4,  8'hFF, 1'b1};
    vt[5] = '{1'b0, 4'd10, 8'h30, 1'b1};
    vt[6] = '{1'b1, 4'd11, 8'h00, 1'b1};
    vt[7] = '{1'b0, 4'd6,  8'h66, 1'b0};
    vt[8] = '{1'b1, 4'd6,  8'h00, 1'b0};
    vt[9] = '{1'b1, 4'd6,  8'h00, 1'b0};

    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_req", port_req, '0);
    chk("rst_pdata", port_data, '0);
    chk("rst_done", done_valid, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1'b1);

    for (int i = 0; i < 10; i++)
      cfg(vt[i].clr, vt[i].idx, vt[i].addr, vt[i].err,
          $sformatf("cfg_vec%0d", i));
    tick();
    chk("cfg_err_pulse", cfg_err, 1'b0);

    // Unicast to port 3, ack two cycles after req.
    push(8'h21, 8'hA5, 10'h008, 2'b00, 1);
    wait_req(10);
    chk("uni_req", port_req, 10'h008);
    chk("uni_slice3", port_data[3*DW +: DW], 8'hA5);
    tick();
    tick();
    port_received = 10'h008;
    tick();
    port_received = '0;
    chk("uni_req_drop", port_req, '0);
    wait_done(5);

    // No route: unbound address and address 0.
    push(8'h44, 8'h11, '0, 2'b01, 1);
    wait_done(6);
    push(8'h00, 8'h22, '0, 2'b01, 1);
    wait_done(6);

    // Broadcast to ports 1, 2, 7.
    cfg(1'b1, 4'd3, 8'h00, 1'b0, "clr3");
    cfg(1'b0, 4'd1, 8'h10, 1'b0, "wr1");
    cfg(1'b0, 4'd2, 8'h20, 1'b0, "wr2");
    cfg(1'b0, 4'd7, 8'h70, 1'b0, "wr7");
    push(8'hFF, 8'h3C, 10'h086, 2'b00, 1);
    wait_req(10);
    chk("bc_req", port_req, 10'h086);
    port_received = 10'h005;
    tick();
    port_received = '0;
    chk("bc_req2", port_req, 10'h082);
    tick();
    port_received = 10'h082;
    tick();
    port_received = '0;
    chk("bc_req_drop", port_req, '0);
    wait_done(3);

    // Timeout: never acked.
    push(8'h10, 8'h55, 10'h002, 2'b10, 1);
    wait_req(10);
    cnt = 0;
    while (port_req != '0 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("tmo_len", cnt, 16);
    wait_done(3);

    // Ack on the last allowed cycle completes OK.
    push(8'h20, 8'h66, 10'h004, 2'b00, 1);
    wait_req(10);
    cnt = 1;
    while (cnt < 16) begin
      tick();
      cnt++;
    end
    chk("ack16_req", port_req, 10'h004);
    port_received = 10'h004;
    tick();
    port_received = '0;
    wait_done(3);

    // Fill the queue with no acks, then drain in order.
    acc = 0;
    in_valid = 1'b1;
    in_addr  = 8'h70;
    for (int c = 0; c < 10; c++) begin
      in_data = 8'(8'hB0 + acc);
      if (in_ready) begin
        sb.push_back('{10'h080, in_data, 2'b00});
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("fill_acc", acc, 5);
    chk("fill_ready", in_ready, 1'b0);
    chk("fill_level", fifo_level, 3'd4);
    for (int k = 0; k < 5; k++) begin
      wait_req(20);
      port_received = 10'h080;
      tick();
      port_received = '0;
      wait_done(5);
    end
    chk("drain_level", fifo_level, 3'd0);

    // Reset in the middle of SEND.
    push(8'h70, 8'h77, 10'h080, 2'b00, 0);
    wait_req(10);
    tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_req", port_req, '0);
    chk("mid_rst_done", done_valid, 1'b0);
    chk("mid_rst_level", fifo_level, 3'd0);
    chk("mid_rst_ready", in_ready, 1'b0);
    reset_n = 1'b1;
    repeat (5) tick();
    push(8'h70, 8'h88, '0, 2'b01, 1);
    wait_done(8);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
